// File: rtl/sd_voice_arbiter.sv
// sd_voice_arbiter: round-robin share of one SD block-read controller among voices.
// Optional SD_ARB_URGENT_EN restricts arbitration to urgent requesters when any exist.
module sd_voice_arbiter #(
  parameter int NUM_VOICES     = 4,
  parameter int BLOCK_BYTES    = 512,
  parameter int TIMEOUT_CYCLES = 1048576
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_VOICES-1:0]   req,
  input  logic [32*NUM_VOICES-1:0] req_addr,
  input  logic [NUM_VOICES-1:0]   urgent,
  output logic [NUM_VOICES-1:0]   grant,
  output logic [NUM_VOICES-1:0]   done,
  output logic                    err,
  output logic [7:0]              voice_data,
  output logic [NUM_VOICES-1:0]   voice_valid,
  output logic                    busy,
  output logic [31:0]             sd_address,
  output logic                    sd_start,
  input  logic                    sd_rdy,
  input  logic [7:0]              sd_data,
  input  logic                    sd_valid
);
  localparam int IW = $clog2(NUM_VOICES);
  localparam int CW = $clog2(BLOCK_BYTES) + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_END = CW'(BLOCK_BYTES);
  localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT_CYCLES);
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_ACC, XFER, RELEASE} state_t;
  state_t state_q, state_d;
  logic [NUM_VOICES-1:0] grant_q, grant_d, done_q, done_d, pool;
  logic [31:0] addr_q, addr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [TW-1:0] to_q, to_d, to_inc;
  logic [IW-1:0] last_q, last_d, pick;
  logic tout_q, tout_d, err_q, err_d, start_q, start_d, xfer_byte;
  function automatic logic [IW-1:0] rr_pick(input logic [NUM_VOICES-1:0] m, input logic [IW-1:0] l);
    logic [IW-1:0] p;
    int idx;
    p = l;
    for (int k = NUM_VOICES; k >= 1; k--) begin
      idx = (int'(l) + k) % NUM_VOICES;
      if (m[idx]) p = IW'(idx);
    end
    return p;
  endfunction
`ifdef SD_ARB_URGENT_EN
  assign pool = |(req & urgent) ? (req & urgent) : req;
`else
  logic unused_urgent;
  assign unused_urgent = ^urgent;
  assign pool = req;
`endif
  assign pick = rr_pick(pool, last_q);
  assign xfer_byte = (state_q == XFER) && sd_valid;
  assign voice_valid = xfer_byte ? grant_q : '0;
  assign voice_data = xfer_byte ? sd_data : '0;
  assign to_inc = (to_q == TO_MAX) ? to_q : to_q + 1'b1;
  assign grant = grant_q;
  assign done = done_q;
  assign err = err_q;
  assign busy = |grant_q;
  assign sd_address = addr_q;
  assign sd_start = start_q;
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    addr_d = addr_q;
    cnt_d = cnt_q;
    to_d = to_q;
    last_d = last_q;
    tout_d = tout_q;
    done_d = '0;
    err_d = 1'b0;
    start_d = 1'b0;
    unique case (state_q)
      IDLE: if (sd_rdy && |pool) begin
        state_d = ISSUE;
        grant_d = NUM_VOICES'(1) << pick;
        addr_d = req_addr[{pick, 5'd0} +: 32];
        cnt_d = '0;
        to_d = '0;
        tout_d = 1'b0;
        last_d = pick;
      end
      ISSUE: begin
        start_d = 1'b1;
        state_d = WAIT_ACC;
      end
      WAIT_ACC: begin
        to_d = to_inc;
        if (!sd_rdy) state_d = XFER;
        else if (to_inc == TO_MAX) {state_d, tout_d} = {RELEASE, 1'b1};
      end
      XFER: if (sd_valid) begin
        cnt_d = cnt_q + 1'b1;
        to_d = '0;
        if (cnt_d == CNT_END) state_d = RELEASE;
      end else begin
        to_d = to_inc;
        if (to_inc == TO_MAX) {state_d, tout_d} = {RELEASE, 1'b1};
      end
      RELEASE: if (sd_rdy) begin
        done_d = grant_q;
        err_d = tout_q;
        grant_d = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      done_q <= '0;
      addr_q <= '0;
      cnt_q <= '0;
      to_q <= '0;
      last_q <= IW'(NUM_VOICES - 1);
      tout_q <= 1'b0;
      err_q <= 1'b0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      done_q <= done_d;
      addr_q <= addr_d;
      cnt_q <= cnt_d;
      to_q <= to_d;
      last_q <= last_d;
      tout_q <= tout_d;
      err_q <= err_d;
      start_q <= start_d;
    end
  end
endmodule

// File: tb/tb_sd_voice_arbiter.sv
// tb_sd_voice_arbiter: directed bench for sd_voice_arbiter with a scripted SD controller.
module tb_sd_voice_arbiter;
  localparam int N = 4, BB = 512, TO = 64;
  logic clk = 0, rst = 1;
  logic [N-1:0] req = '0, urgent = '0;
  logic [32*N-1:0] req_addr = '0;
  logic [N-1:0] grant, done, voice_valid;
  logic err, busy, sd_start;
  logic [7:0] voice_data;
  logic [31:0] sd_address;
  logic sd_rdy = 1, sd_valid = 0;
  logic [7:0] sd_data = '0;
  int n_checks = 0, n_errors = 0;
  int starts = 0, errs = 0, multi = 0, bad_data = 0;
  int vv_cnt[N] = '{default: 0};
  int done_cnt[N] = '{default: 0};
  int order[$];
  logic [N-1:0] grant_prev = '0;
  int base_vv, base_st, base_dn, n;
  always #5 clk = ~clk;
  sd_voice_arbiter #(.NUM_VOICES(N), .BLOCK_BYTES(BB), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .req(req), .req_addr(req_addr), .urgent(urgent),
    .grant(grant), .done(done), .err(err), .voice_data(voice_data),
    .voice_valid(voice_valid), .busy(busy), .sd_address(sd_address),
    .sd_start(sd_start), .sd_rdy(sd_rdy), .sd_data(sd_data), .sd_valid(sd_valid)
  );
  always @(negedge clk) begin
    starts <= starts + int'(sd_start);
    errs <= errs + int'(err);
    if ($countones(grant) > 1) multi <= multi + 1;
    if (voice_valid != 0 && voice_data != sd_data) bad_data <= bad_data + 1;
    for (int i = 0; i < N; i++) begin
      vv_cnt[i] <= vv_cnt[i] + int'(voice_valid[i]);
      done_cnt[i] <= done_cnt[i] + int'(done[i]);
      if (grant_prev == 0 && grant[i]) order.push_back(i);
    end
    grant_prev <= grant;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst = 1;
    req = '0;
    urgent = '0;
    sd_valid = 0;
    sd_rdy = 1;
    tick();
    tick();
    rst = 0;
  endtask
  task automatic accept(input string tag);
    int k;
    for (k = 0; k < 50 && !sd_start; k++) tick();
    if (!sd_start) chk({tag, "_start_timeout"}, 0, 1);
    tick();
    sd_rdy = 0;
    tick();
  endtask
  task automatic stream(input int cnt);
    for (int i = 0; i < cnt; i++) begin
      sd_valid = 1;
      sd_data = 8'(i * 7 + 3);
      tick();
    end
    sd_valid = 0;
  endtask
  task automatic wait_done(input string tag);
    int k = 0;
    do begin
      tick();
      k++;
    end while (done == 0 && k < 100);
    if (done == 0) chk({tag, "_done_timeout"}, 0, 1);
  endtask
  initial begin
    tick();
    chk("rst_grant", 32'(grant), 0);
    chk("rst_done_err", {done, err}, 0);
    chk("rst_busy_start", {busy, sd_start}, 0);
    chk("rst_addr", sd_address, 0);
    chk("rst_vv_data", {voice_valid, voice_data}, 0);
    do_reset();
    // single request from voice 2
    req_addr[64 +: 32] = 32'h0000_1000;
    req = 4'b0100;
    tick();
    chk("single_grant", 32'(grant), 32'b0100);
    chk("single_addr", sd_address, 32'h1000);
    chk("single_busy", 32'(busy), 1);
    base_vv = vv_cnt[2];
    base_st = starts;
    accept("single");
    stream(BB);
    sd_rdy = 1;
    wait_done("single");
    req = '0;
    chk("single_done", 32'(done), 32'b0100);
    chk("single_err", 32'(err), 0);
    chk("single_grant_clr", 32'(grant), 0);
    tick();
    chk("single_strobes", 32'(vv_cnt[2] - base_vv), BB);
    chk("single_other_strobes", 32'(vv_cnt[0] + vv_cnt[1] + vv_cnt[3]), 0);
    chk("single_starts", 32'(starts - base_st), 1);
    chk("single_errs", 32'(errs), 0);
    // fairness from reset
    do_reset();
    order.delete();
    req = 4'b1111;
    for (int t = 0; t < 5; t++) begin
      accept("fair");
      stream(BB);
      sd_rdy = 1;
      wait_done("fair");
      if (t == 4) req = '0;
    end
    tick();
    chk("fair_count", 32'(order.size()), 5);
    for (int t = 0; t < 5 && t < order.size(); t++) chk($sformatf("fair_order%0d", t), 32'(order[t]), 32'(t % 4));
    chk("fair_multihot", 32'(multi), 0);
    chk("fair_data", 32'(bad_data), 0);
    // timeout: 10 bytes then stall with sd_rdy already back high
    req = 4'b1000;
    accept("tout");
    stream(10);
    sd_rdy = 1;
    n = 0;
    do begin
      tick();
      n++;
    end while (done == 0 && n < 200);
    req = '0;
    chk("tout_latency", 32'(n), 65);
    chk("tout_done", 32'(done), 32'b1000);
    chk("tout_err", 32'(err), 1);
    chk("tout_grant_clr", {grant, 3'b0, busy}, 0);
    // request drop mid-transfer, then stray bytes in IDLE
    req = 4'b0010;
    base_vv = vv_cnt[1];
    accept("drop");
    stream(100);
    req = '0;
    stream(BB - 100);
    sd_rdy = 1;
    wait_done("drop");
    chk("drop_done", 32'(done), 32'b0010);
    chk("drop_err", 32'(err), 0);
    tick();
    chk("drop_strobes", 32'(vv_cnt[1] - base_vv), BB);
    base_vv = vv_cnt[0] + vv_cnt[1] + vv_cnt[2] + vv_cnt[3];
    sd_valid = 1;
    sd_data = 8'hAA;
    #1;
    chk("stray_vv", 32'(voice_valid), 0);
    for (int t = 0; t < 4; t++) tick();
    sd_valid = 0;
    tick();
    chk("stray_total", 32'(vv_cnt[0] + vv_cnt[1] + vv_cnt[2] + vv_cnt[3] - base_vv), 0);
    // reset mid-transfer on voice 0
    req = 4'b0001;
    accept("rmid");
    stream(20);
    sd_valid = 1;
    sd_data = 8'h33;
    #1;
    chk("rmid_live_vv", {voice_valid, voice_data}, {4'b0001, 8'h33});
    base_dn = done_cnt[0] + done_cnt[1] + done_cnt[2] + done_cnt[3];
    rst = 1;
    #1;
    chk("rmid_grant_busy", {grant, 3'b0, busy}, 0);
    chk("rmid_vv_data", {voice_valid, voice_data}, 0);
    chk("rmid_addr", sd_address, 0);
    chk("rmid_done_err_start", {done, err, sd_start}, 0);
    sd_valid = 0;
    sd_rdy = 1;
    req = '0;
    tick();
    tick();
    rst = 0;
    req = 4'b0011;
    tick();
    chk("rmid_next_grant", 32'(grant), 32'b0001);
    chk("rmid_no_done", 32'(done_cnt[0] + done_cnt[1] + done_cnt[2] + done_cnt[3] - base_dn), 0);
    // urgent arbitration with last at its reset value
    do_reset();
    req = 4'b1001;
    urgent = 4'b1000;
    tick();
`ifdef SD_ARB_URGENT_EN
    chk("urgent_grant", 32'(grant), 32'b1000);
`else
    chk("urgent_grant", 32'(grant), 32'b0001);
`endif
    do_reset();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/sd_voice_arbiter.md
# sd_voice_arbiter

Shares the single SD-card block-read controller among `NUM_VOICES` voice channels. Each voice requests a block read at its own address. The arbiter grants one voice at a time in round-robin order, issues the start to the controller and routes the returned byte stream to the granted voice only. It sits between the per-voice sample drivers and the SD controller, so several notes can stream samples from one card.

## Interface
- `NUM_VOICES`, 4: number of requesters (2..8).
- `BLOCK_BYTES`, 512: bytes per granted transfer.
- `TIMEOUT_CYCLES`, 1048576: idle cycles tolerated while waiting for accept or the next byte.
- `clk` in 1: system clock; all logic on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req` in NUM_VOICES: per-voice request level; held until matching `done`.
- `req_addr` in 32*NUM_VOICES: voice i block address at bits [32i+31:32i]; sampled at grant.
- `urgent` in NUM_VOICES: voice FIFO near empty; used only with `SD_ARB_URGENT_EN`.
- `grant` out NUM_VOICES: one-hot current owner, all-zero when idle.
- `done` out NUM_VOICES: one-cycle pulse on the owner at transfer end.
- `err` out 1: one-cycle pulse together with `done` when the transfer timed out.
- `voice_data` out 8: byte from controller, shared bus.
- `voice_valid` out NUM_VOICES: one-hot byte strobe to the owner.
- `busy` out 1: high whenever `grant` is non-zero.
- `sd_address` out 32: address to controller; held for the whole transfer.
- `sd_start` out 1: one-cycle start pulse to controller.
- `sd_rdy` in 1: controller idle/ready.
- `sd_data` in 8, `sd_valid` in 1: controller byte stream.

## Operation
- **States:** IDLE, ISSUE, WAIT_ACC, XFER, RELEASE.
- **IDLE:** if `sd_rdy`=1 and any `req` bit is set, pick a winner. The search starts at `last+1` and wraps modulo NUM_VOICES, taking the first set bit. Register the one-hot `grant`, latch `sd_address` from the winner's `req_addr`, clear the byte counter and go to ISSUE. If `sd_rdy`=0, stay in IDLE.
- **ISSUE:** `sd_start`=1 for this cycle only. Go to WAIT_ACC.
- **WAIT_ACC:** wait for `sd_rdy`=0, then go to XFER.
- **XFER:**
  - Each `sd_valid` drives `voice_valid`=`grant` combinationally in the same cycle, `voice_data`=`sd_data`, and counter+1.
  - When the `BLOCK_BYTES`-th byte is accepted, go to RELEASE.
  - `sd_valid` outside XFER is dropped, with `voice_valid`=0.
- **RELEASE:** wait for `sd_rdy`=1. Then pulse `done`=`grant` for one cycle, set `last`=owner index, clear `grant` and return to IDLE.
- **Timeout:** a counter runs in WAIT_ACC and XFER and is cleared by every accepted byte. When it reaches `TIMEOUT_CYCLES`, go to RELEASE with an error flag set. The `done` pulse is then accompanied by `err`=1.
- **Widths:** the byte counter is clog2(BLOCK_BYTES)+1 bits, compared for equality and never wrapping. The timeout counter saturates.
- **Request changes:**
  - `req` dropping during a transfer is ignored; the transfer completes and `done` still pulses.
  - New or other requests wait; no preemption.
- **Reset:**
  - Every output is 0: `grant`, `done`, `err`, `voice_valid`, `voice_data`, `busy`, `sd_start` and `sd_address`.
  - State=IDLE and `last`=NUM_VOICES-1, so voice 0 has first priority.
  - A reset mid-transfer aborts silently, with no `done`.

## Timing
- `req` sampled high in IDLE at edge k: `grant` and `sd_address` are valid after edge k, and `sd_start` is high for the cycle after edge k+1.
- Byte latency is zero: `voice_valid` follows `sd_valid` combinationally while in XFER.
- `done` is high for the cycle after `sd_rdy` is sampled high in RELEASE. The next grant can register one cycle after `done`.
- Simultaneous requests are resolved within one cycle by the round-robin order.
- A voice re-requesting immediately after its `done` goes behind all other pending voices.

## Configuration
- **`SD_ARB_URGENT_EN` defined:** in IDLE, if any `req & urgent` bit is set, round-robin runs only over `req & urgent`. Otherwise it runs over `req`. `last` updates identically in both cases.
- **Not defined:** `urgent` is ignored (left unconnected internally) and arbitration is pure round-robin over `req`.

## Test plan
- **Single request:** voice 2 requests with addr 0x00001000 and a model controller streaming 512 bytes. Required: `grant`=0100, `sd_address`=0x1000, one `sd_start` pulse, 512 `voice_valid[2]` strobes, one `done[2]` pulse, `err`=0.
- **Fairness:** all four voices request continuously. Required: grant order 0,1,2,3,0; `grant` is never multi-hot.
- **Timeout:** the controller accepts then sends 10 bytes and stalls, with `TIMEOUT_CYCLES`=64. Required: after 64 idle cycles the block enters RELEASE; when `sd_rdy` returns, `done` and `err` pulse together and `grant` clears.
- **Request drop and stray bytes:** voice 1 drops `req` mid-transfer. Required: the transfer completes with `done[1]`. `sd_valid` in IDLE produces no `voice_valid`.
- **Reset mid-transfer:** assert `rst` during XFER. Required: all outputs are 0 immediately. The next request from voice 0 is granted first.
- **With `SD_ARB_URGENT_EN`:** voices 0 and 3 request, `urgent`=1000, `last`=3. Required: voice 3 is granted before voice 0. Without the macro, voice 0 is granted first.
